queen_solver_arbiter: RTL and testbench

Shares one stacked eight-queen solver core between two requesters. Grants the core round-robin, clears and starts it per job, and forwards the eight solution row bytes to the granted requester. Closes each job with a one-cycle acknowledge carrying a status code. Sits at the top level beside the solver core; all solver control pins (start, reset) are owned by this block.

---
 rtl/queen_pkg.sv | 17 +
 rtl/queen_rr_pick.sv | 19 +
 rtl/queen_solver_arbiter.sv | 164 ++++++++++++++++
 tb/tb_queen_solver_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/queen_pkg.sv
// Shared types and status codes for the queen solver arbiter.
package queen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    RUN,
    RESP
  } state_e;

  localparam logic [1:0] ST_SOLVED    = 2'b00;
  localparam logic [1:0] ST_NO_ANSWER = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_PROTO_ERR = 2'b11;

endpackage

// File: rtl/queen_rr_pick.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the
// requester that was not served last.
module queen_rr_pick (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = last_served ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/queen_solver_arbiter.sv
// Shares one eight-queen solver core between two requesters: grants it,
// clears/starts it, forwards row bytes and closes each job with a status ack.
module queen_solver_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       user_reset,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [1:0] resp_status,
  output logic [1:0] grant,
  output logic [1:0] row_valid,
  output logic [7:0] row_data,
  output logic [2:0] row_index,
  output logic       s_start,
  output logic       s_reset,
  input  logic       s_ready,
  input  logic [7:0] s_out_bus,
  input  logic       s_done,
  input  logic       s_no_answer
);
  import queen_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [3:0]    beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    status_q, status_d;
  logic [1:0]    row_valid_q, row_valid_d;
  logic [7:0]    row_data_q, row_data_d;
  logic [2:0]    row_index_q, row_index_d;
  logic          s_start_q, s_start_d;
  logic          clr_q, clr_d;
  logic [1:0]    winner;
  logic          term;
  logic [1:0]    term_st;

  queen_rr_pick u_pick (
    .req         (req),
    .last_served (last_q),
    .winner      (winner)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    ack_d       = 2'b00;
    status_d    = 2'b00;
    row_valid_d = 2'b00;
    row_data_d  = 8'h00;
    row_index_d = 3'd0;
    s_start_d   = 1'b0;
    clr_d       = 1'b0;
    term        = 1'b0;
    term_st     = ST_SOLVED;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = winner;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        s_start_d = 1'b1;
        state_d   = START;
      end
      START: begin
        beat_d  = 4'd0;
        tmo_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        tmo_d = tmo_q + TW'(1);
        // Beats past the eighth are never forwarded; they only end the job.
        if (s_ready && beat_q != 4'd8) begin
          row_valid_d = grant_q;
          row_data_d  = s_out_bus;
          row_index_d = beat_q[2:0];
          beat_d      = beat_q + 4'd1;
        end
        if (s_done && s_no_answer) begin
          term    = 1'b1;
          term_st = ST_PROTO_ERR;
        end else if (s_ready && beat_q == 4'd8) begin
          term    = 1'b1;
          term_st = ST_PROTO_ERR;
        end else if (s_done) begin
          term    = 1'b1;
          term_st = (s_ready && beat_q == 4'd7) ? ST_SOLVED : ST_PROTO_ERR;
        end else if (s_no_answer) begin
          term    = 1'b1;
          term_st = (!s_ready && beat_q == 4'd0) ? ST_NO_ANSWER : ST_PROTO_ERR;
        end else if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
          term    = 1'b1;
          term_st = ST_TIMEOUT;
        end
        if (term) begin
          ack_d    = grant_q;
          status_d = term_st;
          clr_d    = term_st[1];
          state_d  = RESP;
        end
      end
      RESP: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (user_reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      beat_q      <= 4'd0;
      tmo_q       <= '0;
      ack_q       <= 2'b00;
      status_q    <= 2'b00;
      row_valid_q <= 2'b00;
      row_data_q  <= 8'h00;
      row_index_q <= 3'd0;
      s_start_q   <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      ack_q       <= ack_d;
      status_q    <= status_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_index_q <= row_index_d;
      s_start_q   <= s_start_d;
      clr_q       <= clr_d;
    end
  end

  assign ack         = ack_q;
  assign resp_status = status_q;
  assign grant       = grant_q;
  assign row_valid   = row_valid_q;
  assign row_data    = row_data_q;
  assign row_index   = row_index_q;
  assign s_start     = s_start_q;
  // The core stays in reset for the whole of user_reset, not just one cycle later.
  assign s_reset     = user_reset | clr_q;

endmodule

// File: tb/tb_queen_solver_arbiter.sv
// Self-checking bench: transaction-level model of grant order, forwarded
// beats and job status, driven with randomized solver behaviour.
module tb_queen_solver_arbiter;

  localparam int TMO = 20;

  typedef enum int {K_SOLVE, K_NOANS, K_BOTH, K_NINTH, K_SILENT} kind_e;

  typedef struct packed {
    logic       rdy;
    logic [7:0] bus;
    logic       done;
    logic       na;
  } cyc_t;

  logic       clk = 1'b0;
  logic       user_reset;
  logic [1:0] req;
  logic [1:0] ack, resp_status, grant, row_valid;
  logic [7:0] row_data;
  logic [2:0] row_index;
  logic       s_start, s_reset;
  logic       s_ready;
  logic [7:0] s_out_bus;
  logic       s_done, s_no_answer;

  int tests = 0;
  int fails = 0;

  int         last_srv = 1;
  cyc_t       stim[$];
  logic [7:0] exp_beats[$];
  logic [7:0] fixed_bytes[$];
  logic [1:0] exp_status;

  always #5 clk = ~clk;

  queen_solver_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .user_reset  (user_reset),
    .req         (req),
    .ack         (ack),
    .resp_status (resp_status),
    .grant       (grant),
    .row_valid   (row_valid),
    .row_data    (row_data),
    .row_index   (row_index),
    .s_start     (s_start),
    .s_reset     (s_reset),
    .s_ready     (s_ready),
    .s_out_bus   (s_out_bus),
    .s_done      (s_done),
    .s_no_answer (s_no_answer)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rr_model(input logic [1:0] r);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
    if (r == 2'b11) return (last_srv == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic drive_idle();
    s_ready     = 1'b0;
    s_out_bus   = 8'h00;
    s_done      = 1'b0;
    s_no_answer = 1'b0;
  endtask

  // Build the per-RUN-cycle solver script and the expected outcome.
  task automatic build(input kind_e k, input int nb, input bit gaps);
    cyc_t       c;
    logic [7:0] b;
    int         nbeats;
    stim.delete();
    exp_beats.delete();
    nbeats = (k == K_NINTH) ? 9 : (k == K_SILENT) ? 0 : nb;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        c = '0;
        stim.push_back(c);
      end
      b = (i < fixed_bytes.size()) ? fixed_bytes[i] : 8'(1 << $urandom_range(0, 7));
      c = '0;
      c.rdy = 1'b1;
      c.bus = b;
      stim.push_back(c);
      if (i < 8) exp_beats.push_back(b);
    end
    c = '0;
    case (k)
      K_SOLVE: begin
        stim[stim.size()-1].done = 1'b1;
        exp_status = (nb == 8) ? 2'b00 : 2'b11;
      end
      K_NOANS: begin
        c.na = 1'b1;
        stim.push_back(c);
        exp_status = (nb == 0) ? 2'b01 : 2'b11;
      end
      K_BOTH: begin
        c.na   = 1'b1;
        c.done = 1'b1;
        stim.push_back(c);
        exp_status = 2'b11;
      end
      K_NINTH: exp_status = 2'b11;
      default: begin
        for (int i = 0; i < TMO; i++) stim.push_back(c);
        exp_status = 2'b10;
      end
    endcase
  endtask

  // Called from an IDLE cycle's negedge; returns at the following IDLE cycle.
  task automatic run_job(input logic [1:0] r, input bit drop, input string tag);
    logic [1:0] g;
    logic [7:0] got_d[$];
    logic [2:0] got_i[$];
    int         ack_k;
    int         term_k;
    bit         seen;
    g      = rr_model(r);
    term_k = stim.size() - 1;
    ack_k  = -1;
    seen   = 1'b0;
    req    = r;
    @(negedge clk);
    check({tag, ".clr_grant"}, grant, g);
    check({tag, ".clr_sreset"}, s_reset, 1'b1);
    check({tag, ".clr_sstart"}, s_start, 1'b0);
    if (drop) req = 2'b00;
    @(negedge clk);
    check({tag, ".start_sstart"}, s_start, 1'b1);
    check({tag, ".start_sreset"}, s_reset, 1'b0);
    for (int k = 0; k < TMO + 6 && !seen; k++) begin
      @(negedge clk);
      if (row_valid != 2'b00) begin
        check({tag, ".rv_owner"}, row_valid, g);
        got_d.push_back(row_data);
        got_i.push_back(row_index);
      end
      if (ack != 2'b00) begin
        seen  = 1'b1;
        ack_k = k;
        check({tag, ".ack"}, ack, g);
        check({tag, ".status"}, resp_status, exp_status);
        check({tag, ".resp_sreset"}, s_reset, exp_status[1]);
        drive_idle();
      end else if (k < stim.size()) begin
        s_ready     = stim[k].rdy;
        s_out_bus   = stim[k].bus;
        s_done      = stim[k].done;
        s_no_answer = stim[k].na;
      end else begin
        drive_idle();
      end
    end
    drive_idle();
    check({tag, ".ack_cycle"}, ack_k, term_k + 1);
    check({tag, ".nbeats"}, got_d.size(), exp_beats.size());
    for (int i = 0; i < got_d.size() && i < exp_beats.size(); i++) begin
      check($sformatf("%s.data%0d", tag, i), got_d[i], exp_beats[i]);
      check($sformatf("%s.idx%0d", tag, i), got_i[i], i);
    end
    @(negedge clk);
    check({tag, ".idle_grant"}, grant, 2'b00);
    check({tag, ".idle_ack"}, ack, 2'b00);
    if (g != 2'b00) last_srv = g[1] ? 1 : 0;
  endtask

  initial begin
    kind_e k;
    int    nb;
    logic [1:0] r;
    user_reset = 1'b1;
    req        = 2'b00;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("rst.grant", grant, 2'b00);
    check("rst.ack", ack, 2'b00);
    check("rst.row_valid", row_valid, 2'b00);
    check("rst.status", resp_status, 2'b00);
    check("rst.row_data", row_data, 8'h00);
    check("rst.row_index", row_index, 3'd0);
    check("rst.s_start", s_start, 1'b0);
    check("rst.s_reset", s_reset, 1'b1);
    user_reset = 1'b0;
    #1;
    check("rst.s_reset_release", s_reset, 1'b0);
    @(negedge clk);

    // Tie held for three jobs: grants alternate 01, 10, 01.
    check("tie.first_pick", rr_model(2'b11), 2'b01);
    for (int j = 0; j < 3; j++) begin
      build(K_NOANS, 0, 1'b0);
      run_job(2'b11, 1'b0, $sformatf("tie%0d", j));
    end
    req = 2'b00;

    fixed_bytes = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h02, 8'h40, 8'h08, 8'h04};
    build(K_SOLVE, 8, 1'b0);
    run_job(2'b01, 1'b0, "solve8");
    fixed_bytes.delete();

    build(K_SOLVE, 5, 1'b1);
    run_job(2'b10, 1'b1, "done5");
    build(K_SILENT, 0, 1'b0);
    run_job(2'b01, 1'b1, "timeout");
    build(K_BOTH, $urandom_range(0, 3), 1'b1);
    run_job(2'b11, 1'b1, "both");
    build(K_NINTH, 0, 1'b1);
    run_job(2'b10, 1'b1, "ninth");

    for (int j = 0; j < 10; j++) begin
      k  = kind_e'($urandom_range(0, 4));
      nb = (k == K_SOLVE) ? (($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 8))
                          : $urandom_range(0, 8);
      r  = 2'($urandom_range(1, 3));
      build(k, nb, 1'($urandom_range(0, 1)));
      run_job(r, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
    end

    // user_reset mid-RUN after three beats.
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_ready   = 1'b1;
      s_out_bus = 8'(1 << i);
    end
    @(negedge clk);
    drive_idle();
    user_reset = 1'b1;
    #1;
    check("ures.s_reset_now", s_reset, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ures.grant", grant, 2'b00);
      check("ures.ack", ack, 2'b00);
      check("ures.row_valid", row_valid, 2'b00);
      check("ures.s_reset", s_reset, 1'b1);
    end
    last_srv   = 1;
    user_reset = 1'b0;
    #1;
    check("ures.s_reset_off", s_reset, 1'b0);
    build(K_SOLVE, 8, 1'b1);
    run_job(2'b10, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
